// File: rtl/fetch_pkg.sv
// Shared widths, defaults and FSM state type for the instruction fetch front end.
package fetch_pkg;

    localparam int          ADDR_W    = 32;
    localparam int          INSTR_W   = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; flush wins over push/pop in the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // a full FIFO still takes a push when the head leaves in the same cycle
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC, credit-limited imem requests, response queue to decode, redirect squash.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect raises sticky fetch_fault and stops fetch.
module instr_fetch_unit #(
    parameter int                ADDR_W   = fetch_pkg::ADDR_W,
    parameter int                INSTR_W  = fetch_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(fetch_pkg::RESET_PC),
    parameter int                DEPTH    = 4
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    output logic               fetch_fault
);

    import fetch_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e              state, state_n;
    logic [ADDR_W-1:0]         pc, tgt, pend_addr;
    logic [CW-1:0]             inflight, q_count, squash, squash_n, squash_after;
    logic [CW:0]               credit_sum;
    logic                      acc, misalign, fault_q;
    logic                      pend_full, pend_empty, q_full, q_empty, unused_bits;
    logic [ADDR_W+INSTR_W-1:0] q_head;

    assign acc            = imem_req_valid && imem_req_ready;
    assign credit_sum     = {1'b0, inflight} + {1'b0, q_count};
    // valid depends only on registered state, so it cannot drop before ready except on redirect
    assign imem_req_valid = (state == RUN) && (credit_sum < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign squash_after   = inflight + CW'(acc) - CW'(imem_resp_valid);

`ifdef FETCH_ALIGN_CHECK_EN
    assign tgt      = redirect_pc;
    assign misalign = |redirect_pc[1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                           fault_q <= 1'b0;
        else if (redirect_valid && misalign) fault_q <= 1'b1;
    end

    assign unused_bits = &{1'b0, pend_full, pend_empty, q_full};
`else
    assign tgt         = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign misalign    = 1'b0;
    assign fault_q     = 1'b0;
    assign unused_bits = &{1'b0, pend_full, pend_empty, q_full, redirect_pc[1:0]};
`endif

    assign fetch_fault = fault_q;

    always_comb begin
        state_n  = state;
        squash_n = squash;
        if (imem_resp_valid && squash != '0) squash_n = squash - 1'b1;
        case (state)
            BOOT:    state_n = RUN;
            RUN:     state_n = RUN;
            FLUSH:   if (squash_n == '0 && !fault_q) state_n = RUN;
            default: state_n = BOOT;
        endcase
        // redirect overrides everything; a faulted fetch parks in FLUSH for good
        if (redirect_valid) begin
            squash_n = squash_after;
            state_n  = (squash_after != '0 || misalign || fault_q) ? FLUSH : RUN;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= BOOT;
            pc     <= RESET_PC;
            squash <= '0;
        end else begin
            state  <= state_n;
            squash <= squash_n;
            if (redirect_valid) pc <= tgt;
            else if (acc)       pc <= pc + ADDR_W'(4);
        end
    end

    // pending addresses are never flushed: they must stay paired with responses still on the way
    fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pend (
        .clock     (clock),
        .reset     (reset),
        .flush     (1'b0),
        .push      (acc),
        .push_data (pc),
        .pop       (imem_resp_valid),
        .pop_data  (pend_addr),
        .count     (inflight),
        .full      (pend_full),
        .empty     (pend_empty)
    );

    fetch_fifo #(.WIDTH(ADDR_W + INSTR_W), .DEPTH(DEPTH)) u_queue (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (imem_resp_valid && squash == '0 && !redirect_valid),
        .push_data ({pend_addr, imem_resp_data}),
        .pop       (dec_ready),
        .pop_data  (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign dec_valid = !q_empty;
    assign dec_pc    = q_empty ? '0 : q_head[ADDR_W+INSTR_W-1:INSTR_W];
    assign dec_instr = q_empty ? INSTR_W'(NOP_INSTR) : q_head[INSTR_W-1:0];

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage front end: the requester side of the instruction-memory read interface.
- Owns the PC and issues word-aligned read requests to instr_mem with a valid/ready handshake.
- Receives in-order responses and buffers {pc, instr} pairs in a small queue feeding decode.
- Handles branch/jump redirects by flushing buffered instructions and squashing in-flight responses.

Parameters:
- ADDR_W, 32, PC and memory address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 4, instruction queue depth; also the credit limit on in-flight plus buffered entries (power of 2, ≥2).

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  ADDR_W  byte address, bits[1:0]=0.
- imem_resp_valid  in  1  response data valid; in request order; no backpressure.
- imem_resp_data  in  INSTR_W  instruction word.
- redirect_valid  in  1  branch/jump taken; single-cycle pulse.
- redirect_pc  in  ADDR_W  new fetch target.
- dec_valid  out  1  queue head valid.
- dec_ready  in  1  decode consumes head.
- dec_instr  out  INSTR_W  head instruction.
- dec_pc  out  ADDR_W  address of head instruction.
- fetch_fault  out  1  sticky misaligned-redirect flag (see Optional Feature).

Behaviour:
- Reset values: pc=RESET_PC; imem_req_valid=0; imem_req_addr=RESET_PC; dec_valid=0; dec_instr=0; dec_pc=0; fetch_fault=0; queue empty; inflight=0; squash=0; state=BOOT.
- FSM states and transitions:
  - BOOT: one cycle after reset release with no request; then RUN.
  - RUN: issue when credit is available.
  - FLUSH: entered on redirect while inflight>0 after the redirect edge. No issue in FLUSH. Return to RUN in the cycle squash reaches 0.
- Credit rule: imem_req_valid=1 in RUN iff inflight + queue_count < DEPTH. Once asserted, valid and addr stay stable until ready is seen.
- Request accept (valid&&ready): pc += 4; inflight++; the address is pushed into a pending-address FIFO of depth DEPTH.
- Response:
  - If squash>0: discard, squash--, inflight--, pop pending address.
  - Else: push {pending_addr, data} to the queue, inflight--, pop pending address.
- dec_valid = queue not empty. Head pops on dec_valid&&dec_ready. Latency is 1 cycle: response at edge N gives dec_valid at edge N+1.
- Redirect (highest priority) in the same cycle:
  - Queue cleared and dec_valid=0 next cycle. A same-cycle decode pop is ignored.
  - pc=redirect_pc.
  - squash = inflight after counting this cycle's accepted request and this cycle's response.
  - Any pending imem_req_valid is dropped. A request accepted that same cycle is counted in squash.
  - Next state: FLUSH if squash>0, else RUN.
- Redirect during FLUSH: squash reloads with the current inflight count; pc updates again.
- Simultaneous push and pop on a full queue is legal; count is unchanged. Pointers wrap modulo DEPTH.
- PC increments wrap modulo 2^ADDR_W.
- Reset mid-operation: all state returns to reset values immediately. Outstanding memory responses after reset are the memory's responsibility; the memory is reset by the same signal.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined: a redirect with redirect_pc[1:0]!=0 sets fetch_fault=1 (sticky until reset). The FSM enters FLUSH, then holds without issuing; dec_valid drains normally.
- Undefined: redirect_pc[1:0] is forced to 0, and fetch_fault is tied to 0.

Decomposition:
- Package fetch_pkg: INSTR_W, ADDR_W, RESET_PC default, NOP_INSTR=32'h0000_0000, FSM state enum {BOOT, RUN, FLUSH}.
- Sub-module fetch_fifo: parameterised synchronous FIFO (width, depth) with push/pop/flush, count, full/empty. Instantiated twice: once for the pending-address FIFO, once for the instruction queue.

Test Plan:
- Reset, mem always ready, resp 1 cycle later with data=addr^32'hA5A5_0000, dec_ready=1 -> requests at 0x0,0x4,0x8,...; dec_pc/dec_instr match in order; first dec_valid at cycle 4 after reset release.
- dec_ready=0 held -> exactly DEPTH=4 requests issued then imem_req_valid=0; queue holds 0x0..0xC; releasing dec_ready resumes issue at 0x10.
- imem_req_ready low for 3 cycles -> imem_req_addr stable at 0x8 and valid held; no PC advance.
- Redirect to 0x100 with 2 requests in flight -> next dec_valid=0; FSM in FLUSH; two responses discarded; next dec_pc=0x100, then 0x104.
- Redirect in the same cycle as a response and a dec pop -> the response is squashed or dropped, the queue is empty next cycle, and no stale pc appears at dec_pc.
- FETCH_ALIGN_CHECK_EN defined, redirect to 0x102 -> fetch_fault=1, no further requests; undefined -> fetch resumes at 0x100.
